// File: rtl/usb_pkt_gen.sv
// USB data-packet generator: streams PID byte, payload read from the packet RAM, then CRC16.
// Define USB_PKT_CRC_EN to include the CRC16 generator and the CRC_LO/CRC_HI trailer bytes.
module usb_pkt_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic [7:0] base_addr,
    input  logic [7:0] length,
    output logic       ram_en,
    output logic [7:0] ram_addr,
    input  logic [7:0] ram_rdata,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       busy,
    output logic       done
);

`ifdef USB_PKT_CRC_EN
    typedef enum logic [2:0] {ST_IDLE, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_PID, ST_DATA} state_e;
`endif

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] addr_q, addr_d;
    logic       ram_en_q, ram_en_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       tx_sop_q, tx_sop_d;
    logic       tx_eop_q, tx_eop_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       xfer;
    logic       last_byte;
    logic       pkt_end;
    logic       more_fetch;
    logic [8:0] idx_p2;

`ifdef USB_PKT_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_upd;

    // Reflected CRC16 (0x8005 -> 0xA001), one byte folded in LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] din);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ din[i]) c = (c >> 1) ^ 16'hA001;
            else               c = c >> 1;
        end
        return c;
    endfunction

    assign crc_upd = crc16_byte(crc_q, tx_data_q);
`endif

    assign xfer       = tx_valid_q & tx_ready;
    assign last_byte  = (idx_q == len_q - 8'd1);
    assign idx_p2     = {1'b0, idx_q} + 9'd2;
    assign more_fetch = (idx_p2 < {1'b0, len_q});

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        ram_en_d   = ram_en_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_sop_d   = tx_sop_q;
        tx_eop_d   = tx_eop_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pkt_end    = 1'b0;
`ifdef USB_PKT_CRC_EN
        crc_d      = crc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = length;
                    idx_d      = 8'd0;
                    addr_d     = base_addr;
                    ram_en_d   = (length != 8'd0);
                    tx_data_d  = {~pid, pid};
                    tx_valid_d = 1'b1;
                    tx_sop_d   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_PID;
`ifdef USB_PKT_CRC_EN
                    tx_eop_d   = 1'b0;
                    crc_d      = 16'hFFFF;
`else
                    tx_eop_d   = (length == 8'd0);
`endif
                end
            end

            ST_PID: begin
                if (xfer) begin
                    tx_sop_d = 1'b0;
                    if (len_q != 8'd0) begin
                        tx_data_d = ram_rdata;
                        addr_d    = addr_q + 8'd1;
                        ram_en_d  = (len_q > 8'd1);
                        state_d   = ST_DATA;
`ifndef USB_PKT_CRC_EN
                        tx_eop_d  = (len_q == 8'd1);
`endif
                    end else begin
`ifdef USB_PKT_CRC_EN
                        tx_data_d = ~crc_q[7:0];
                        state_d   = ST_CRC_LO;
`else
                        pkt_end   = 1'b1;
`endif
                    end
                end
            end

            ST_DATA: begin
                if (xfer) begin
                    idx_d = idx_q + 8'd1;
`ifdef USB_PKT_CRC_EN
                    crc_d = crc_upd;
`endif
                    if (last_byte) begin
`ifdef USB_PKT_CRC_EN
                        tx_data_d = ~crc_upd[7:0];
                        state_d   = ST_CRC_LO;
`else
                        pkt_end   = 1'b1;
`endif
                    end else begin
                        // Next payload byte is read combinationally from the address fetched now.
                        tx_data_d = ram_rdata;
                        addr_d    = addr_q + 8'd1;
                        ram_en_d  = more_fetch;
`ifndef USB_PKT_CRC_EN
                        tx_eop_d  = (idx_p2 == {1'b0, len_q});
`endif
                    end
                end
            end

`ifdef USB_PKT_CRC_EN
            ST_CRC_LO: begin
                if (xfer) begin
                    tx_data_d = ~crc_q[15:8];
                    tx_eop_d  = 1'b1;
                    state_d   = ST_CRC_HI;
                end
            end

            ST_CRC_HI: begin
                if (xfer) pkt_end = 1'b1;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pkt_end) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            tx_sop_d   = 1'b0;
            tx_eop_d   = 1'b0;
            ram_en_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            addr_q     <= 8'd0;
            ram_en_q   <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef USB_PKT_CRC_EN
            crc_q      <= 16'hFFFF;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            ram_en_q   <= ram_en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef USB_PKT_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign ram_en   = ram_en_q;
    assign ram_addr = addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_sop   = tx_sop_q;
    assign tx_eop   = tx_eop_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_usb_pkt_gen.sv
// Scoreboard bench for usb_pkt_gen: a packet-level model queues expected bytes and fetch
// addresses; a negedge monitor compares every transfer. Honours USB_PKT_CRC_EN like the RTL.
module tb_usb_pkt_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pid;
    logic [7:0] base_addr;
    logic [7:0] length;
    logic       ram_en;
    logic [7:0] ram_addr;
    logic [7:0] ram_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sop;
    logic       tx_eop;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    logic [7:0] mem [256];
    beat_t      sb_q[$];
    logic [7:0] addr_exp_q[$];
    logic [7:0] cap_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int xfer_cnt    = 0;
    int done_cnt    = 0;
    int pkts_sent   = 0;
    int aborted     = 0;
    logic rand_ready = 1'b0;

    logic       exp_done;
    logic       hold_prev;
    logic [7:0] prev_data, prev_addr;
    logic       prev_sop, prev_eop;

    usb_pkt_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pid       (pid),
        .base_addr (base_addr),
        .length    (length),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .busy      (busy),
        .done      (done)
    );

    assign ram_rdata = mem[ram_addr];

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Monitor: compares every transfer, done timing, ram_en/ram_addr and back-pressure hold.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            exp_done  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            check("done", done, exp_done);
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (hold_prev) begin
                check("hold_valid", tx_valid, 1'b1);
                check("hold_data", tx_data, prev_data);
                check("hold_sop", tx_sop, prev_sop);
                check("hold_eop", tx_eop, prev_eop);
                check("hold_addr", ram_addr, prev_addr);
            end
            if (tx_valid) check("ram_en", ram_en, addr_exp_q.size() != 0);
            else          check("ram_en_idle", ram_en, 1'b0);
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                cap_q.push_back(tx_data);
                if (ram_en && addr_exp_q.size() != 0) check("ram_addr", ram_addr, addr_exp_q.pop_front());
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_byte: got 0x%02h, expected no transfer at %0t", tx_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("tx_sop", tx_sop, e.sop);
                    check("tx_eop", tx_eop, e.eop);
                    exp_done = e.eop;
                end
            end
            hold_prev = tx_valid && !tx_ready;
            prev_data = tx_data;
            prev_addr = ram_addr;
            prev_sop  = tx_sop;
            prev_eop  = tx_eop;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy still high after %0d cycles, expected low", n);
        end
    endtask

    // Reference model: the whole expected packet is derived from pid, base, length and RAM.
    task automatic start_pkt(input logic [3:0] p, input logic [7:0] b, input logic [7:0] l);
        logic [7:0] a;
        logic [15:0] crc;
        wait_idle();
        crc = 16'hFFFF;
`ifdef USB_PKT_CRC_EN
        sb_q.push_back({~p, p, 1'b1, 1'b0});
`else
        sb_q.push_back({~p, p, 1'b1, l == 8'd0});
`endif
        for (int i = 0; i < int'(l); i++) begin
            a = 8'((int'(b) + i) % 256);
            addr_exp_q.push_back(a);
            crc = ref_crc_step(crc, mem[a]);
`ifdef USB_PKT_CRC_EN
            sb_q.push_back({mem[a], 1'b0, 1'b0});
`else
            sb_q.push_back({mem[a], 1'b0, i == int'(l) - 1});
`endif
        end
`ifdef USB_PKT_CRC_EN
        crc = ~crc;
        sb_q.push_back({crc[7:0], 1'b0, 1'b0});
        sb_q.push_back({crc[15:8], 1'b0, 1'b1});
`endif
        pid       = p;
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pkts_sent++;
        check("accept_valid", tx_valid, 1'b1);
        check("accept_busy", busy, 1'b1);
        check("accept_sop", tx_sop, 1'b1);
        check("accept_pid", tx_data, {~p, p});
    endtask

    task automatic wait_done_cycles(input int exp_cycles);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 2000);
        check("done_latency", n, exp_cycles);
    endtask

    task automatic spam_while_busy();
        int n = 0;
        while (busy && n < 5000) begin
            start     = 1'b1;
            pid       = 4'($urandom);
            base_addr = 8'($urandom);
            length    = 8'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_cap(input string name, input logic [7:0] exp_q[$]);
        check({name, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) check(name, cap_q[i], exp_q[i]);
    endtask

    task automatic ready_high();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int c0;
        int n;
        int trail;
`ifdef USB_PKT_CRC_EN
        trail = 2;
`else
        trail = 0;
`endif
        reset     = 1'b1;
        start     = 1'b0;
        pid       = 4'h0;
        base_addr = 8'h00;
        length    = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_sop", tx_sop, 1'b0);
        check("rst_tx_eop", tx_eop, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_ram_addr", ram_addr, 8'h00);
        reset = 1'b0;

        // Zero-length packet.
        ready_high();
        cap_q.delete();
        start_pkt(4'h3, 8'h40, 8'd0);
        wait_done_cycles(1 + trail);
`ifdef USB_PKT_CRC_EN
        exp_q = '{8'hC3, 8'h00, 8'h00};
`else
        exp_q = '{8'hC3};
`endif
        check_cap("len0_stream", exp_q);

        // "123456789" at 0x10, ready held high, then with random back-pressure.
        for (int i = 0; i < 9; i++) mem[8'h10 + i] = 8'(8'h31 + i);
        exp_q.delete();
        exp_q.push_back(8'h4B);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
`ifdef USB_PKT_CRC_EN
        exp_q.push_back(8'hC8);
        exp_q.push_back(8'hB4);
`endif
        cap_q.delete();
        start_pkt(4'hB, 8'h10, 8'd9);
        wait_done_cycles(9 + 1 + trail);
        check_cap("ascii_stream", exp_q);

        rand_ready = 1'b1;
        cap_q.delete();
        start_pkt(4'hB, 8'h10, 8'd9);
        wait_idle();
        check_cap("ascii_bp_stream", exp_q);

        // Address wrap from 0xFE with start pulses hammered while busy.
        start_pkt(4'($urandom), 8'hFE, 8'd4);
        spam_while_busy();

        // Reset in the middle of the payload, then a clean packet.
        ready_high();
        c0 = xfer_cnt;
        start_pkt(4'h5, 8'h20, 8'd10);
        n = 0;
        while (xfer_cnt - c0 < 4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        #1;
        reset = 1'b1;
        #1;
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ram_en", ram_en, 1'b0);
        check("abort_tx_data", tx_data, 8'h00);
        check("abort_tx_eop", tx_eop, 1'b0);
        sb_q.delete();
        addr_exp_q.delete();
        aborted++;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start_pkt(4'hA, 8'h20, 8'd10);
        wait_done_cycles(10 + 1 + trail);

        // Randomized packets.
        for (int k = 0; k < 40; k++) begin : rand_pkts
            logic [7:0] l;
            wait_idle();
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            rand_ready = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 40));
            start_pkt(4'($urandom), 8'($urandom), l);
            if ($urandom_range(0, 1) == 1) spam_while_busy();
        end

        // Maximum length wrapping through 0xFF.
        wait_idle();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rand_ready = 1'b1;
        start_pkt(4'h7, 8'h80, 8'd255);
        wait_idle();

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        check("fetches_drained", addr_exp_q.size(), 0);
        check("done_count", done_cnt, pkts_sent - aborted);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
